// File: rtl/mem_arbiter.sv
// Shares the single Hack Memory port between the CPU data port (requester 0)
// and a DMA/program-loader engine (requester 1) using round-robin with a bounded burst lock.
module mem_arbiter #(
  parameter int BURST_MAX = 4,
  parameter bit CPU_FIRST = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [14:0] addr0,
  input  logic [15:0] wdata0,
  output logic        gnt0,
  output logic        ack0,
  output logic [15:0] rdata0,
  output logic        hold0,
  input  logic        req1,
  input  logic        we1,
  input  logic [14:0] addr1,
  input  logic [15:0] wdata1,
  input  logic        lock1,
  output logic        gnt1,
  output logic        ack1,
  output logic [15:0] rdata1,
  output logic        mem_load,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_in,
  input  logic [15:0] mem_out
);

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(BURST_MAX);

  state_t     state, next_state;
  logic [3:0] burst_cnt, next_burst_cnt;
  logic       last_served, next_last_served;

  // Every grant lasts one cycle and is followed by IDLE, which is also the ack
  // cycle, so arbitration only ever happens in IDLE.
  always_comb begin
    next_state       = IDLE;
    next_burst_cnt   = burst_cnt;
    next_last_served = last_served;
    if (state == IDLE) begin
      if (req0 && req1) begin
        if (lock1 && last_served && (burst_cnt < BURST_LIMIT)) begin
          next_state     = SERVE1;
          next_burst_cnt = burst_cnt + 4'd1;
        end else if (last_served) begin
          next_state = SERVE0;
        end else begin
          next_state = SERVE1;
        end
      end else if (req0) begin
        next_state = SERVE0;
      end else if (req1) begin
        next_state = SERVE1;
      end

      if (next_state == SERVE0) begin
        next_burst_cnt   = 4'd0;
        next_last_served = 1'b0;
      end else if (next_state == SERVE1) begin
        next_last_served = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      burst_cnt   <= 4'd0;
      last_served <= CPU_FIRST;
    end else begin
      state       <= next_state;
      burst_cnt   <= next_burst_cnt;
      last_served <= next_last_served;
    end
  end

  // Read data is captured at the end of the grant cycle; ack follows one cycle later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= 16'h0000;
      rdata1 <= 16'h0000;
    end else begin
      ack0 <= (state == SERVE0);
      ack1 <= (state == SERVE1);
      if (state == SERVE0) rdata0 <= mem_out;
      if (state == SERVE1) rdata1 <= mem_out;
    end
  end

  always_comb begin
    mem_load = 1'b0;
    mem_addr = 15'h0000;
    mem_in   = 16'h0000;
    case (state)
      SERVE0: begin
        mem_load = we0;
        mem_addr = addr0;
        mem_in   = wdata0;
      end
      SERVE1: begin
        mem_load = we1;
        mem_addr = addr1;
        mem_in   = wdata1;
      end
      default: begin
        mem_load = 1'b0;
        mem_addr = 15'h0000;
        mem_in   = 16'h0000;
      end
    endcase
  end

  assign gnt0  = (state == SERVE0);
  assign gnt1  = (state == SERVE1);
  assign hold0 = req0 & ~ack0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a cycle-counting transaction model with its own memory image.
module tb_mem_arbiter;

  localparam int BURST_MAX = 4;
  localparam bit CPU_FIRST = 1'b1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [14:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, ack0, hold0, gnt1, ack1, mem_load;
  logic [15:0] rdata0, rdata1, mem_in, mem_out;
  logic [14:0] mem_addr;

  logic [15:0] tb_mem [0:32767];
  logic [15:0] ref_mem [0:31];

  int tests_run = 0;
  int fail_count = 0;

  mem_arbiter #(.BURST_MAX(BURST_MAX), .CPU_FIRST(CPU_FIRST)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0), .hold0(hold0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
    .mem_load(mem_load), .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clock = ~clock;

  // Stand-in for the Hack Memory block: combinational read, write on the rising edge.
  assign mem_out = tb_mem[mem_addr];
  always @(posedge clock) if (mem_load) tb_mem[mem_addr] <= mem_in;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0000; req1 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if ({gnt0, gnt1, ack0, ack1, mem_load, hold0} !== 6'b000001) begin
      fail_count++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000001", {gnt0, gnt1, ack0, ack1, mem_load, hold0});
    end
    tests_run++;
    if ({rdata0, rdata1, mem_addr} !== 47'h0) begin
      fail_count++;
      $display("[TB] FAIL reset_data: rdata0=%h rdata1=%h mem_addr=%h expected all zero", rdata0, rdata1, mem_addr);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    tests_run++;
    if ({gnt0, ack0, hold0} !== 3'b001) begin
      fail_count++;
      $display("[TB] FAIL release_c0: got %b expected 001", {gnt0, ack0, hold0});
    end
    step();
    tests_run++;
    if ({gnt0, ack0, hold0} !== 3'b101) begin
      fail_count++;
      $display("[TB] FAIL release_c1: got %b expected 101", {gnt0, ack0, hold0});
    end
    step();
    tests_run++;
    if ({gnt0, ack0, hold0} !== 3'b010) begin
      fail_count++;
      $display("[TB] FAIL release_c2: got %b expected 010", {gnt0, ack0, hold0});
    end
    req0 = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    apply_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0010; wdata0 = 16'h1234;
    #1;
    tests_run++;
    if (mem_load !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL wr_idle_load: got %b expected 0", mem_load);
    end
    step();
    tests_run++;
    if ({gnt0, mem_load, mem_addr, mem_in} !== {2'b11, 15'h0010, 16'h1234}) begin
      fail_count++;
      $display("[TB] FAIL wr_gnt: got gnt0=%b load=%b addr=%h in=%h expected 1 1 0010 1234", gnt0, mem_load, mem_addr, mem_in);
    end
    step();
    tests_run++;
    if ({ack0, mem_load} !== 2'b10) begin
      fail_count++;
      $display("[TB] FAIL wr_ack: got %b expected 10", {ack0, mem_load});
    end
    we0 = 1'b0;
    step();
    tests_run++;
    if ({gnt0, mem_load} !== 2'b10) begin
      fail_count++;
      $display("[TB] FAIL rd_gnt: got %b expected 10", {gnt0, mem_load});
    end
    step();
    tests_run++;
    if ({ack0, rdata0} !== {1'b1, 16'h1234}) begin
      fail_count++;
      $display("[TB] FAIL rd_ack: got ack0=%b rdata0=%h expected 1 1234", ack0, rdata0);
    end
    req0 = 1'b0;
    step();
  endtask

  task automatic test_alternate();
    int who;
    int prev;
    apply_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
    addr0 = 15'h0001; addr1 = 15'h0002;
    prev = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k % 2 == 1) begin
        who = ((k - 1) / 2) % 2;
        prev = who;
        tests_run++;
        if ({gnt0, gnt1, ack0, ack1} !== {who == 0, who == 1, 2'b00}) begin
          fail_count++;
          $display("[TB] FAIL alt_gnt_c%0d: got %b expected grant to %0d", k, {gnt0, gnt1, ack0, ack1}, who);
        end
      end else begin
        tests_run++;
        if ({gnt0, gnt1, ack0, ack1} !== {2'b00, prev == 0, prev == 1}) begin
          fail_count++;
          $display("[TB] FAIL alt_ack_c%0d: got %b expected ack to %0d", k, {gnt0, gnt1, ack0, ack1}, prev);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  task automatic test_burst();
    int cnt1;
    int cnt2;
    bit seen;
    apply_reset();
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 15'h0003;
    step();
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0004;
    cnt1 = 0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      step();
      if (gnt0) seen = 1'b1;
      else if (gnt1) cnt1++;
    end
    tests_run++;
    if (!seen || cnt1 != BURST_MAX) begin
      fail_count++;
      $display("[TB] FAIL burst_first: got %0d grants to req1 (gnt0 seen=%b) expected %0d", cnt1, seen, BURST_MAX);
    end
    cnt2 = 0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      step();
      if (gnt0) seen = 1'b1;
      else if (gnt1) cnt2++;
    end
    tests_run++;
    if (!seen || cnt2 != BURST_MAX + 1) begin
      fail_count++;
      $display("[TB] FAIL burst_cleared: got %0d grants to req1 (gnt0 seen=%b) expected %0d", cnt2, seen, BURST_MAX + 1);
    end
    step();
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    step();
  endtask

  task automatic test_mixed();
    tb_mem[0] = 16'h00AA;
    apply_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0000;
    req1 = 1'b1; we1 = 1'b1; addr1 = 15'h4000; wdata1 = 16'hFFFF;
    step();
    tests_run++;
    if ({gnt0, gnt1, mem_load, mem_addr} !== {3'b100, 15'h0000}) begin
      fail_count++;
      $display("[TB] FAIL mix_cpu_gnt: got gnt0=%b gnt1=%b load=%b addr=%h expected 1 0 0 0000", gnt0, gnt1, mem_load, mem_addr);
    end
    step();
    tests_run++;
    if ({ack0, rdata0} !== {1'b1, 16'h00AA}) begin
      fail_count++;
      $display("[TB] FAIL mix_cpu_rd: got ack0=%b rdata0=%h expected 1 00aa", ack0, rdata0);
    end
    req0 = 1'b0;
    step();
    tests_run++;
    if ({gnt1, mem_load, mem_addr, mem_in} !== {2'b11, 15'h4000, 16'hFFFF}) begin
      fail_count++;
      $display("[TB] FAIL mix_dma_wr: got gnt1=%b load=%b addr=%h in=%h expected 1 1 4000 ffff", gnt1, mem_load, mem_addr, mem_in);
    end
    step();
    we1 = 1'b0;
    step();
    step();
    tests_run++;
    if ({ack1, rdata1, rdata0} !== {1'b1, 16'hFFFF, 16'h00AA}) begin
      fail_count++;
      $display("[TB] FAIL mix_screen_rd: got ack1=%b rdata1=%h rdata0=%h expected 1 ffff 00aa", ack1, rdata1, rdata0);
    end
    req1 = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = 15'h0020; wdata1 = 16'hBEEF;
    step();
    tests_run++;
    if ({gnt1, mem_load} !== 2'b11) begin
      fail_count++;
      $display("[TB] FAIL mid_gnt: got %b expected 11", {gnt1, mem_load});
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({gnt1, mem_load, ack1} !== 3'b000) begin
      fail_count++;
      $display("[TB] FAIL mid_abort: got %b expected 000", {gnt1, mem_load, ack1});
    end
    req1 = 1'b0;
    step();
    tests_run++;
    if ({gnt1, ack1} !== 2'b00) begin
      fail_count++;
      $display("[TB] FAIL mid_no_ack: got %b expected 00", {gnt1, ack1});
    end
    @(negedge clock);
    reset = 1'b1;
    step();
    tests_run++;
    if ({gnt0, gnt1, ack0, ack1} !== 4'b0000) begin
      fail_count++;
      $display("[TB] FAIL mid_idle: got %b expected 0000", {gnt0, gnt1, ack0, ack1});
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0020;
    step();
    tests_run++;
    if (gnt1 !== 1'b1) begin
      fail_count++;
      $display("[TB] FAIL mid_new_gnt: got %b expected 1", gnt1);
    end
    step();
    tests_run++;
    if ({ack1, rdata1} !== {1'b1, 16'h0000}) begin
      fail_count++;
      $display("[TB] FAIL mid_new_ack: got ack1=%b rdata1=%h expected 1 0000", ack1, rdata1);
    end
    req1 = 1'b0;
    step();
  endtask

  // Transaction model: a grant decided at cycle t occupies cycle t+1 and is
  // acknowledged at t+2, when the port is free to be arbitrated again.
  task automatic test_random();
    int sched, cur_gnt, cur_ack, prev_gnt, free_at, win, m_burst;
    bit m_last;
    logic [15:0] cap0, cap1, exp_r0, exp_r1, exp_in;
    logic [14:0] exp_addr;
    logic [5:0] exp_ctl;
    for (int i = 0; i < 32; i++) begin
      tb_mem[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    apply_reset();
    sched = -1; prev_gnt = -1; free_at = 0; m_burst = 0; m_last = CPU_FIRST;
    exp_r0 = 16'h0; exp_r1 = 16'h0; cap0 = 16'h0; cap1 = 16'h0;
    for (int t = 0; t < 3000; t++) begin
      cur_gnt = sched;
      sched = -1;
      cur_ack = prev_gnt;
      prev_gnt = cur_gnt;
      if (cur_ack == 0) exp_r0 = cap0;
      if (cur_ack == 1) exp_r1 = cap1;

      if ((cur_ack == 0 && $urandom_range(0, 1) == 1) || (!req0 && $urandom_range(0, 2) == 0)) begin
        req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        addr0 = 15'($urandom_range(0, 31)); wdata0 = 16'($urandom);
      end else if (cur_ack == 0) begin
        req0 = 1'b0;
      end
      if ((cur_ack == 1 && $urandom_range(0, 3) != 0) || (!req1 && $urandom_range(0, 1) == 0)) begin
        req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        addr1 = 15'($urandom_range(0, 31)); wdata1 = 16'($urandom);
      end else if (cur_ack == 1) begin
        req1 = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) lock1 = ~lock1;

      if (t >= free_at && (req0 || req1)) begin
        if (req0 && req1) begin
          if (lock1 && m_last && m_burst < BURST_MAX) begin
            win = 1;
            m_burst++;
          end else begin
            win = m_last ? 0 : 1;
          end
        end else begin
          win = req0 ? 0 : 1;
        end
        if (win == 0) m_burst = 0;
        m_last = (win == 1);
        sched = win;
        free_at = t + 2;
      end

      exp_addr = 15'h0; exp_in = 16'h0;
      if (cur_gnt == 0) begin
        exp_addr = addr0; exp_in = wdata0;
        cap0 = ref_mem[addr0[4:0]];
        if (we0) ref_mem[addr0[4:0]] = wdata0;
      end else if (cur_gnt == 1) begin
        exp_addr = addr1; exp_in = wdata1;
        cap1 = ref_mem[addr1[4:0]];
        if (we1) ref_mem[addr1[4:0]] = wdata1;
      end
      exp_ctl = {cur_gnt == 0, cur_gnt == 1, cur_ack == 0, cur_ack == 1,
                 (cur_gnt == 0 && we0) || (cur_gnt == 1 && we1), req0 && cur_ack != 0};
      #1;
      tests_run++;
      if ({gnt0, gnt1, ack0, ack1, mem_load, hold0} !== exp_ctl) begin
        fail_count++;
        $display("[TB] FAIL rnd_ctl t=%0d: got %b expected %b", t, {gnt0, gnt1, ack0, ack1, mem_load, hold0}, exp_ctl);
      end
      tests_run++;
      if ({mem_addr, mem_in} !== {exp_addr, exp_in}) begin
        fail_count++;
        $display("[TB] FAIL rnd_port t=%0d: got addr=%h in=%h expected addr=%h in=%h", t, mem_addr, mem_in, exp_addr, exp_in);
      end
      tests_run++;
      if ({rdata0, rdata1} !== {exp_r0, exp_r1}) begin
        fail_count++;
        $display("[TB] FAIL rnd_rdata t=%0d: got %h %h expected %h %h", t, rdata0, rdata1, exp_r0, exp_r1);
      end
      step();
    end
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) tb_mem[i] = 16'h0000;
    test_reset();
    test_write_read();
    test_alternate();
    test_burst();
    test_mixed();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
